// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the arbiter and the split instruction/data memory slaves.
// master = arbiter view (drives grants, responses and the bus); slave = requester/memory environment view.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_size;
    logic        d_signed;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        HSEL1;
    logic        HSEL2;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [2:0]  hsize;
    logic        is_signed;
    logic [3:0]  hprot;
    logic [31:0] instruction;
    logic [31:0] load_out;
    logic        hready_inst;
    logic        hready_data;
    logic        hresp_inst;
    logic        hresp_data;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_size, d_signed,
        input  instruction, load_out, hready_inst, hready_data, hresp_inst, hresp_data,
        output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
        output HSEL1, HSEL2, haddr, hwrite, hwdata, hsize, is_signed, hprot
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_size, d_signed,
        output instruction, load_out, hready_inst, hready_data, hresp_inst, hresp_data,
        input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
        input  HSEL1, HSEL2, haddr, hwrite, hwdata, hsize, is_signed, hprot
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data port arbiter onto split ROM/RAM buses, one transaction in flight; gnt at N, rvalid at N+2.
// Requesters hold req until gnt; each low hready cycle of the selected slave stretches the data phase by one.
module mem_port_arbiter #(
    parameter logic [3:0] ROM_NIB      = 4'h0,
    parameter logic [3:0] RAM_NIB      = 4'h1,
    parameter int         STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.master bus
);
    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state, state_nxt;

    logic [STARVE_W-1:0] starve_cnt;
    logic                owner_d;
    logic                dec_err;
    logic                is_store;
    logic                hsel1_q, hsel2_q, hwrite_q, is_signed_q;
    logic [31:0]         haddr_q, hwdata_q;
    logic [2:0]          hsize_q;
    logic [3:0]          hprot_q;
    logic [31:0]         i_rdata_q, d_rdata_q;

    logic                fetch_wins, grant_i, grant_d, addr_err, done;
    logic                slv_ready, slv_resp, sel_err;
    logic [31:0]         sel_addr, rd_now;
    logic [3:0]          sel_nib;

    assign fetch_wins = bus.i_req && (!bus.d_req || (starve_cnt >= STARVE_MAX));
    assign sel_addr   = fetch_wins ? bus.i_addr : bus.d_addr;
    assign sel_nib    = sel_addr[31:28];
    // Fetches may only hit ROM; data may load from either memory but store only to RAM.
    assign sel_err    = fetch_wins ? (sel_nib != ROM_NIB)
                                   : !((sel_nib == RAM_NIB) || ((sel_nib == ROM_NIB) && !bus.d_we));

    assign slv_ready  = hsel1_q ? bus.hready_inst : bus.hready_data;
    assign slv_resp   = hsel1_q ? bus.hresp_inst  : bus.hresp_data;
    assign rd_now     = is_store ? 32'h0 : (hsel1_q ? bus.instruction : bus.load_out);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Reset gates every pulse so an aborted transaction never reports a response.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        addr_err  = 1'b0;
        done      = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        state_nxt = ADDR;
                        grant_i   = fetch_wins;
                        grant_d   = !fetch_wins;
                    end
                end
                ADDR: begin
                    addr_err  = dec_err;
                    state_nxt = dec_err ? IDLE : DATA;
                end
                DATA: begin
                    if (slv_ready) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt  <= '0;
            owner_d     <= 1'b0;
            dec_err     <= 1'b0;
            is_store    <= 1'b0;
            hsel1_q     <= 1'b0;
            hsel2_q     <= 1'b0;
            hwrite_q    <= 1'b0;
            is_signed_q <= 1'b0;
            haddr_q     <= '0;
            hwdata_q    <= '0;
            hsize_q     <= '0;
            hprot_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            if (grant_i || grant_d) begin
                owner_d     <= grant_d;
                dec_err     <= sel_err;
                is_store    <= grant_d && bus.d_we;
                hsel1_q     <= !sel_err && (sel_nib == ROM_NIB);
                hsel2_q     <= !sel_err && (sel_nib == RAM_NIB);
                haddr_q     <= sel_addr;
                hwrite_q    <= grant_d && bus.d_we;
                hwdata_q    <= (grant_d && bus.d_we) ? bus.d_wdata : 32'h0;
                hsize_q     <= grant_d ? bus.d_size : 3'b010;
                is_signed_q <= grant_d && bus.d_signed;
                hprot_q     <= {3'b000, grant_d};
            end else if (addr_err || done) begin
                hsel1_q     <= 1'b0;
                hsel2_q     <= 1'b0;
                hwrite_q    <= 1'b0;
                is_signed_q <= 1'b0;
                haddr_q     <= '0;
                hwdata_q    <= '0;
                hsize_q     <= '0;
                hprot_q     <= '0;
            end

            if (done && !owner_d) i_rdata_q <= rd_now;
            if (done &&  owner_d) d_rdata_q <= rd_now;

            if (state == IDLE) begin
                if (!bus.i_req || grant_i)     starve_cnt <= '0;
                else if (starve_cnt < STARVE_MAX) starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end

    assign bus.i_gnt     = grant_i;
    assign bus.d_gnt     = grant_d;
    assign bus.i_rvalid  = done && !owner_d;
    assign bus.d_rvalid  = done &&  owner_d;
    assign bus.i_err     = !owner_d && (addr_err || (done && slv_resp));
    assign bus.d_err     =  owner_d && (addr_err || (done && slv_resp));
    assign bus.i_rdata   = (done && !owner_d) ? rd_now : i_rdata_q;
    assign bus.d_rdata   = (done &&  owner_d) ? rd_now : d_rdata_q;

    assign bus.HSEL1     = hsel1_q;
    assign bus.HSEL2     = hsel2_q;
    assign bus.haddr     = haddr_q;
    assign bus.hwrite    = hwrite_q;
    assign bus.hwdata    = hwdata_q;
    assign bus.hsize     = hsize_q;
    assign bus.is_signed = is_signed_q;
    assign bus.hprot     = hprot_q;
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ROM_NIB, default 4'h0: value of addr[31:28] that selects instruction memory.
REQ-002 Parameter RAM_NIB, default 4'h1: value of addr[31:28] that selects data memory.
REQ-003 Parameter STARVE_LIMIT, default 4: consecutive lost arbitrations after which the fetch port wins.
REQ-004 Ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- i_req  in  1  fetch request.
- i_addr  in  32  fetch address.
- i_gnt  out  1  fetch request accepted, one-cycle pulse.
- i_rvalid  out  1  fetch data valid, one-cycle pulse.
- i_rdata  out  32  fetched instruction.
- i_err  out  1  fetch error, one-cycle pulse.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_size  in  3  access size code.
- d_signed  in  1  load sign-extend.
- d_gnt  out  1  data request accepted, one-cycle pulse.
- d_rvalid  out  1  data response, one-cycle pulse.
- d_rdata  out  32  load data.
- d_err  out  1  data error, one-cycle pulse.
- HSEL1  out  1  instruction memory select.
- HSEL2  out  1  data memory select.
- haddr  out  32  bus address.
- hwrite  out  1  bus write.
- hwdata  out  32  bus write data.
- hsize  out  3  bus size.
- is_signed  out  1  bus sign control.
- hprot  out  4  bus protection: 4'b0000 for fetch, 4'b0001 for data.
- instruction  in  32  instruction memory read data.
- load_out  in  32  data memory read data.
- hready_inst  in  1  instruction slave ready.
- hready_data  in  1  data slave ready.
- hresp_inst  in  1  instruction slave error.
- hresp_data  in  1  data slave error.

Function
REQ-005 The FSM SHALL have three states: IDLE, ADDR and DATA; exactly one transaction is outstanding at any time.
REQ-006 In IDLE with at least one request, the FSM SHALL grant one port, pulse its gnt for one cycle, register its address and control onto the bus outputs at the same edge, and enter ADDR.
REQ-007 Priority SHALL be data over fetch, except that when starve_cnt >= STARVE_LIMIT the fetch port wins.
REQ-008 starve_cnt SHALL increment (saturating at STARVE_LIMIT) when fetch requests but data wins, and SHALL clear when fetch is granted or i_req is low in IDLE.
REQ-009 Decode SHALL be: addr[31:28]==ROM_NIB sets HSEL1; addr[31:28]==RAM_NIB sets HSEL2; any other value sets neither.
REQ-010 A granted fetch that decodes to RAM, or a store that decodes to ROM, SHALL be treated as a decode error.
REQ-011 On a decode error, no HSEL SHALL assert; the FSM SHALL go IDLE->ADDR->IDLE and pulse the granted port's err, with rvalid low, in the ADDR-exit cycle.
REQ-012 The transition ADDR->DATA SHALL be unconditional after one cycle.
REQ-013 In DATA, the FSM SHALL wait for hready of the selected slave (hready_inst for HSEL1, hready_data for HSEL2). When it is high, the FSM SHALL capture instruction or load_out into the owning port's rdata, pulse rvalid (stores included, rdata = 0), pulse err if the matching hresp is high, and return to IDLE.
REQ-014 Bus outputs SHALL hold stable from grant until DATA completes, and SHALL then return to zero.
REQ-015 Minimum latency SHALL be gnt at cycle N, rvalid at N+2; each extra low-hready cycle adds one cycle.
REQ-016 A requester SHALL hold req, addr and controls until its gnt; inputs are not sampled outside IDLE.
REQ-017 rdata SHALL hold its last captured value until the next response to the same port.
REQ-018 Requests that arrive in the completion cycle SHALL be arbitrated in the following IDLE cycle, with no back-to-back grant in the same cycle as rvalid.

Reset
REQ-019 reset, sampled at a clock edge in any state including mid-transaction, SHALL force IDLE, starve_cnt = 0, and all outputs to 0.
REQ-020 An in-flight transaction aborted by reset SHALL produce no rvalid and no err.

Verification
REQ-021 Fetch only, i_addr 0x0000_0010, hready_inst=1 -> i_gnt at N, HSEL1=1 and haddr=0x10 in N+1..N+2, i_rvalid with i_rdata = instruction at N+2.
REQ-022 Simultaneous i_req and d_req (load at 0x1000_0004) held continuously -> data granted the first 4 times, fetch granted on the 5th arbitration, starve_cnt back to 0.
REQ-023 Store d_addr 0x1000_0008, d_wdata 0xDEADBEEF, hready_data low 3 cycles -> hwrite=1 and hwdata held, d_rvalid at N+5, d_rdata=0.
REQ-024 Data load at 0x2000_0000, or fetch at 0x1000_0000 -> no HSEL, err pulse at N+1, rvalid low, FSM idle at N+2.
REQ-025 Load with hresp_data=1 at completion -> d_rvalid and d_err both pulse in the same cycle.
REQ-026 Reset asserted in DATA while hready_data=0 -> next cycle all outputs 0, no d_rvalid; a subsequent fetch completes normally.
